// File: rtl/poly_codec_pkg.sv
// Shared constants, state encoding and coefficient classification for the
// polynomial coefficient link codec.
package poly_codec_pkg;

  localparam int DATA_SIZE    = 16;
  localparam int POLY_SIZE    = 16;
  localparam int SCALE_FACTOR = 2;
  localparam int N            = DATA_SIZE + SCALE_FACTOR;
  localparam int IDX_W        = $clog2(N);

  typedef enum logic {
    COLLECT = 1'b0,
    OUTPUT  = 1'b1
  } state_t;

  // Returns {legal, bit}: only 0 and 1 are legal data coefficients.
  function automatic logic [1:0] coeff_is_bit(input logic [POLY_SIZE-1:0] coeff);
    logic legal;
    legal = (coeff[POLY_SIZE-1:1] == {(POLY_SIZE-1){1'b0}});
    return {legal, coeff[0] & legal};
  endfunction

endpackage

// File: rtl/poly_coeff_check.sv
// Classifies one received coefficient: data coefficients must be 0/1,
// guard coefficients must be 0.
module poly_coeff_check
  import poly_codec_pkg::*;
(
  input  logic [POLY_SIZE-1:0] coeff,
  input  logic                 is_guard,
  output logic                 coeff_bit,
  output logic                 bad
);

  logic [1:0] verdict_s;

  // Decode the coefficient into a data bit and an error indication
  always_comb begin
    verdict_s = coeff_is_bit(coeff);
    coeff_bit = 1'b0;
    bad       = 1'b0;
    if (is_guard) begin
      bad = (coeff != {POLY_SIZE{1'b0}});
    end else begin
      coeff_bit = verdict_s[0];
      bad       = ~verdict_s[1];
    end
  end

endmodule

// File: rtl/poly_stream_decoder.sv
// Serial receive end of the polynomial coefficient link: collects N beats per
// frame, rebuilds the data word and flags malformed frames.
module poly_stream_decoder
  import poly_codec_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic [POLY_SIZE-1:0] coeff_in,
  input  logic                 coeff_sof,
  input  logic                 coeff_valid,
  output logic                 coeff_ready,
  output logic [DATA_SIZE-1:0] data_out,
  output logic                 frame_err,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 sync_err
);

  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(N - 1);
  localparam logic [IDX_W-1:0] FIRST_GUARD = IDX_W'(DATA_SIZE);

  state_t               state_r, state_s;
  logic [IDX_W-1:0]     idx_r, idx_s, pos_s;
  logic [DATA_SIZE-1:0] acc_r, acc_s, data_out_s;
  logic                 err_r, err_s;
  logic                 frame_err_s, data_valid_s, sync_err_s, coeff_ready_s;
  logic                 beat_s, coeff_bit_s, coeff_bad_s;

  assign beat_s = coeff_valid & coeff_ready;
  // A start-of-frame beat always lands at index 0, whatever idx currently holds.
  assign pos_s  = coeff_sof ? {IDX_W{1'b0}} : idx_r;

  poly_coeff_check u_check (
    .coeff     (coeff_in),
    .is_guard  (pos_s >= FIRST_GUARD),
    .coeff_bit (coeff_bit_s),
    .bad       (coeff_bad_s)
  );

  // Next-state, frame assembly and output staging
  always_comb begin
    state_s      = state_r;
    idx_s        = idx_r;
    acc_s        = acc_r;
    err_s        = err_r;
    data_out_s   = data_out;
    frame_err_s  = frame_err;
    data_valid_s = data_valid;
    sync_err_s   = 1'b0;
    case (state_r)
      COLLECT: begin
        if (beat_s && !coeff_sof && (idx_r == {IDX_W{1'b0}})) begin
          sync_err_s = 1'b1;
        end else if (beat_s) begin
          sync_err_s = coeff_sof && (idx_r != {IDX_W{1'b0}});
          acc_s      = coeff_sof ? {DATA_SIZE{1'b0}} : acc_r;
          for (int k = 0; k < DATA_SIZE; k++) begin
            acc_s[k] = (pos_s == IDX_W'(k)) ? coeff_bit_s : acc_s[k];
          end
          err_s = (coeff_sof ? 1'b0 : err_r) | coeff_bad_s;
          if (pos_s == LAST_IDX) begin
            state_s      = OUTPUT;
            idx_s        = {IDX_W{1'b0}};
            data_out_s   = acc_s;
            frame_err_s  = err_s;
            data_valid_s = 1'b1;
          end else begin
            idx_s = pos_s + IDX_W'(1);
          end
        end else begin
          idx_s = idx_r;
        end
      end
      OUTPUT: begin
        if (data_ready) begin
          state_s      = COLLECT;
          data_valid_s = 1'b0;
        end else begin
          state_s = OUTPUT;
        end
      end
      default: begin
        state_s      = COLLECT;
        idx_s        = {IDX_W{1'b0}};
        data_valid_s = 1'b0;
      end
    endcase
    // Ready is registered from the next state, so data_ready never reaches it combinationally.
    coeff_ready_s = (state_s == COLLECT);
  end

  // State, collection and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= COLLECT;
      idx_r       <= {IDX_W{1'b0}};
      acc_r       <= {DATA_SIZE{1'b0}};
      err_r       <= 1'b0;
      coeff_ready <= 1'b0;
      data_out    <= {DATA_SIZE{1'b0}};
      frame_err   <= 1'b0;
      data_valid  <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      state_r     <= state_s;
      idx_r       <= idx_s;
      acc_r       <= acc_s;
      err_r       <= err_s;
      coeff_ready <= coeff_ready_s;
      data_out    <= data_out_s;
      frame_err   <= frame_err_s;
      data_valid  <= data_valid_s;
      sync_err    <= sync_err_s;
    end
  end

endmodule
